// File: rtl/ntt_wb_addr_gen.sv
// ntt_wb_addr_gen
//   Write-back address generator for the radix-16 NTT datapath. Each address
//   group issued by the read AGU is captured into an in-order FIFO while the PE
//   pipeline computes. When the PE returns a result group, the oldest address
//   group is popped, every lane address is mapped to a conflict-free
//   (bank, row) pair, and the result is registered onto the write port. Groups
//   are counted per stage, and wb_done pulses with the final write of the last
//   stage.
//
// Ports
//   clk, rst      clock (rising edge), asynchronous active-high reset
//   clear         synchronous flush of FIFO, counters and sticky flags
//   ord_valid     ord_in carries an address group this cycle
//   ord_in        lane k address at [k*AW +: AW]
//   res_valid     PE result group available; pops the oldest address group
//   wr_en         per-lane write enable (all ones on a write cycle)
//   wr_bank       lane k bank at [k*RADIX_LOG +: RADIX_LOG]
//   wr_row        lane k row at [k*RW +: RW]
//   wr_stage      NTT stage of the group on wr_*
//   wb_done       pulse with the last write of the last stage
//   fifo_full     DEPTH groups held
//   fifo_empty    no groups held
//   overflow      sticky: push attempted while full without a pop
//   underflow     sticky: res_valid while empty
module ntt_wb_addr_gen #(
    parameter int LOGN      = 12,
    parameter int RADIX_LOG = 4,
    parameter int AW        = LOGN,
    parameter int DEPTH     = 8,
    localparam int LANES    = 2 ** RADIX_LOG,
    localparam int RW       = AW - RADIX_LOG,
    localparam int STAGES   = LOGN / RADIX_LOG,
    localparam int SW       = (STAGES > 1) ? $clog2(STAGES) : 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clear,
    input  logic                       ord_valid,
    input  logic [LANES*AW-1:0]        ord_in,
    input  logic                       res_valid,
    output logic [LANES-1:0]           wr_en,
    output logic [LANES*RADIX_LOG-1:0] wr_bank,
    output logic [LANES*RW-1:0]        wr_row,
    output logic [SW-1:0]              wr_stage,
    output logic                       wb_done,
    output logic                       fifo_full,
    output logic                       fifo_empty,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int GW     = LOGN - RADIX_LOG;   // group counter width
    localparam int GPS    = 2 ** GW;            // groups per stage
    localparam int PW     = $clog2(DEPTH);      // FIFO pointer width
    localparam int DIGITS = AW / RADIX_LOG;     // radix digits per address

    logic [LANES*AW-1:0] mem_q [DEPTH];

    logic [PW-1:0]              wptr_q, wptr_d;
    logic [PW-1:0]              rptr_q, rptr_d;
    logic [PW:0]                cnt_q, cnt_d;
    logic [GW-1:0]              grp_q, grp_d;
    logic [SW-1:0]              stg_q, stg_d;
    logic [LANES-1:0]           en_q, en_d;
    logic [LANES*RADIX_LOG-1:0] bank_q, bank_d;
    logic [LANES*RW-1:0]        row_q, row_d;
    logic [SW-1:0]              wstg_q, wstg_d;
    logic                       done_q, done_d;
    logic                       ovf_q, ovf_d;
    logic                       udf_q, udf_d;

    logic                       full, empty, push, pop;
    logic [LANES*AW-1:0]        head;
    logic [LANES*RADIX_LOG-1:0] map_bank;
    logic [LANES*RW-1:0]        map_row;
    logic [RADIX_LOG-1:0]       dsum;

    assign full  = (cnt_q == (PW+1)'(DEPTH));
    assign empty = (cnt_q == '0);
    assign pop   = res_valid & ~empty;
    // A pop frees the slot this cycle, so a push into a full FIFO is accepted
    // alongside it. Pushing into an empty FIFO never pops in the same cycle.
    assign push  = ord_valid & (~full | pop);
    assign head  = mem_q[rptr_q];

    // Bank = digit sum modulo the radix (carry dropped); row = address without
    // its lowest digit. Lanes of one AGU group differ in exactly one digit
    // position, so their digit sums cover all banks.
    always_comb begin
        map_bank = '0;
        map_row  = '0;
        dsum     = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            dsum = '0;
            for (int unsigned j = 0; j < DIGITS; j++) begin
                dsum = dsum + head[k*AW + j*RADIX_LOG +: RADIX_LOG];
            end
            map_bank[k*RADIX_LOG +: RADIX_LOG] = dsum;
            map_row[k*RW +: RW]                = head[k*AW + RADIX_LOG +: RW];
        end
    end

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        cnt_d  = cnt_q;
        grp_d  = grp_q;
        stg_d  = stg_q;
        en_d   = '0;
        bank_d = bank_q;
        row_d  = row_q;
        wstg_d = wstg_q;
        done_d = 1'b0;
        ovf_d  = ovf_q;
        udf_d  = udf_q;

        if (clear) begin
            wptr_d = '0;
            rptr_d = '0;
            cnt_d  = '0;
            grp_d  = '0;
            stg_d  = '0;
            bank_d = '0;
            row_d  = '0;
            wstg_d = '0;
            ovf_d  = 1'b0;
            udf_d  = 1'b0;
        end else begin
            if (ord_valid & full & ~res_valid) ovf_d = 1'b1;
            if (res_valid & empty)             udf_d = 1'b1;

            if (push) wptr_d = wptr_q + PW'(1);

            if (pop) begin
                rptr_d = rptr_q + PW'(1);
                en_d   = '1;
                bank_d = map_bank;
                row_d  = map_row;
                wstg_d = stg_q;
                if (grp_q == GW'(GPS - 1)) begin
                    grp_d = '0;
                    if (stg_q == SW'(STAGES - 1)) begin
                        stg_d  = '0;
                        done_d = 1'b1;
                    end else begin
                        stg_d = stg_q + SW'(1);
                    end
                end else begin
                    grp_d = grp_q + GW'(1);
                end
            end

            case ({push, pop})
                2'b10:   cnt_d = cnt_q + (PW+1)'(1);
                2'b01:   cnt_d = cnt_q - (PW+1)'(1);
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push & ~clear) mem_q[wptr_q] <= ord_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            grp_q  <= '0;
            stg_q  <= '0;
            en_q   <= '0;
            bank_q <= '0;
            row_q  <= '0;
            wstg_q <= '0;
            done_q <= 1'b0;
            ovf_q  <= 1'b0;
            udf_q  <= 1'b0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            cnt_q  <= cnt_d;
            grp_q  <= grp_d;
            stg_q  <= stg_d;
            en_q   <= en_d;
            bank_q <= bank_d;
            row_q  <= row_d;
            wstg_q <= wstg_d;
            done_q <= done_d;
            ovf_q  <= ovf_d;
            udf_q  <= udf_d;
        end
    end

    assign wr_en      = en_q;
    assign wr_bank    = bank_q;
    assign wr_row     = row_q;
    assign wr_stage   = wstg_q;
    assign wb_done    = done_q;
    assign fifo_full  = full;
    assign fifo_empty = empty;
    assign overflow   = ovf_q;
    assign underflow  = udf_q;

endmodule

// File: tb/tb_ntt_wb_addr_gen.sv
// Testbench for ntt_wb_addr_gen: directed scenarios plus randomized traffic,
// each checked against a queue-based reference model.
module tb_ntt_wb_addr_gen;

    localparam int LANES = 16;
    localparam int AW    = 12;
    localparam int RW    = 8;
    localparam int DEPTH = 8;
    localparam int VW    = LANES + LANES*4 + LANES*RW + 2 + 5;

    typedef logic [LANES*AW-1:0] grp_t;

    logic                  clk = 1'b0;
    logic                  rst = 1'b0;
    logic                  clear = 1'b0;
    logic                  ord_valid = 1'b0;
    grp_t                  ord_in = '0;
    logic                  res_valid = 1'b0;
    logic [LANES-1:0]      wr_en;
    logic [LANES*4-1:0]    wr_bank;
    logic [LANES*RW-1:0]   wr_row;
    logic [1:0]            wr_stage;
    logic                  wb_done;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  overflow;
    logic                  underflow;

    ntt_wb_addr_gen #(.LOGN(12), .RADIX_LOG(4), .AW(12), .DEPTH(8)) dut (
        .clk(clk), .rst(rst), .clear(clear),
        .ord_valid(ord_valid), .ord_in(ord_in), .res_valid(res_valid),
        .wr_en(wr_en), .wr_bank(wr_bank), .wr_row(wr_row), .wr_stage(wr_stage),
        .wb_done(wb_done), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
        .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    logic [VW-1:0] dut_vec;
    assign dut_vec = {wr_en, wr_bank, wr_row, wr_stage, wb_done,
                      fifo_full, fifo_empty, overflow, underflow};

    int checks = 0;
    int errors = 0;

    // Reference model state
    grp_t               mq[$];
    int                 npop;
    logic               m_over, m_under;
    logic [LANES-1:0]   e_en;
    logic [LANES*4-1:0] e_bank;
    logic [LANES*RW-1:0] e_row;
    logic [1:0]         e_stage;
    logic               e_done;

    function automatic logic [LANES*4-1:0] bank_of(grp_t g);
        logic [LANES*4-1:0] r = '0;
        for (int k = 0; k < LANES; k++) begin
            int a = int'(g[k*AW +: AW]);
            r[k*4 +: 4] = 4'((a % 16 + (a / 16) % 16 + a / 256) % 16);
        end
        return r;
    endfunction

    function automatic logic [LANES*RW-1:0] row_of(grp_t g);
        logic [LANES*RW-1:0] r = '0;
        for (int k = 0; k < LANES; k++) begin
            r[k*RW +: RW] = RW'(int'(g[k*AW +: AW]) / 16);
        end
        return r;
    endfunction

    function automatic grp_t rand_grp();
        grp_t g = '0;
        for (int k = 0; k < LANES; k++) g[k*AW +: AW] = AW'($urandom);
        return g;
    endfunction

    function automatic logic [VW-1:0] exp_vec();
        return {e_en, e_bank, e_row, e_stage, e_done,
                mq.size() == DEPTH, mq.size() == 0, m_over, m_under};
    endfunction

    task automatic model_reset();
        mq.delete();
        npop    = 0;
        m_over  = 1'b0;
        m_under = 1'b0;
        e_en    = '0;
        e_bank  = '0;
        e_row   = '0;
        e_stage = '0;
        e_done  = 1'b0;
    endtask

    // Drive one cycle of inputs, advance past the edge, update the model.
    task automatic cycle(input logic v, input grp_t d, input logic rv, input logic clr);
        ord_valid = v;
        ord_in    = d;
        res_valid = rv;
        clear     = clr;
        @(posedge clk);
        #1;
        if (clr) begin
            model_reset();
        end else begin
            int sz = mq.size();
            bit p_pop  = rv && sz > 0;
            bit p_push = v && (sz < DEPTH || p_pop);
            if (v && sz == DEPTH && !rv) m_over = 1'b1;
            if (rv && sz == 0)           m_under = 1'b1;
            e_en   = '0;
            e_done = 1'b0;
            if (p_pop) begin
                grp_t h = mq.pop_front();
                e_en    = '1;
                e_bank  = bank_of(h);
                e_row   = row_of(h);
                e_stage = 2'((npop / 256) % 3);
                e_done  = (npop % 768) == 767;
                npop    = (npop + 1) % 768;
            end
            if (p_push) mq.push_back(d);
        end
        ord_valid = 1'b0;
        res_valid = 1'b0;
        clear     = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        #1;
        checks++;
        if (dut_vec !== VW'(4)) begin
            errors++;
            $display("FAIL reset_state got %h want %h", dut_vec, VW'(4));
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        cycle(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_map_bank_k();
        grp_t g = '0;
        logic [LANES*4-1:0]  wb = '0;
        logic [LANES*RW-1:0] wr = '0;
        logic [LANES*4-1:0]  held;
        for (int k = 0; k < LANES; k++) begin
            g[k*AW +: AW] = AW'(k * 256);
            wb[k*4 +: 4]  = 4'(k);
            wr[k*RW +: RW] = RW'(k * 16);
        end
        cycle(1'b1, g, 1'b0, 1'b0);
        checks++;
        if (wr_en !== 16'h0000) begin
            errors++;
            $display("FAIL map1_no_early_write got %h want 0000", wr_en);
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (wr_en !== 16'hFFFF || wr_bank !== wb || wr_row !== wr || wr_stage !== 2'd0) begin
            errors++;
            $display("FAIL map1_write got en=%h bank=%h row=%h stg=%0d want en=ffff bank=%h row=%h stg=0",
                     wr_en, wr_bank, wr_row, wr_stage, wb, wr);
        end
        held = wr_bank;
        cycle(1'b0, '0, 1'b0, 1'b0);
        checks++;
        if (wr_en !== 16'h0000 || wr_bank !== held || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL map1_hold got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_map_shift();
        grp_t g = '0;
        logic [LANES*4-1:0]  wb = '0;
        logic [LANES*RW-1:0] wr = '0;
        logic [15:0] seen = '0;
        for (int k = 0; k < LANES; k++) begin
            g[k*AW +: AW]  = AW'(k * 16 + 1);
            wb[k*4 +: 4]   = 4'((k + 1) % 16);
            wr[k*RW +: RW] = RW'(k);
        end
        cycle(1'b1, g, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (wr_bank !== wb || wr_row !== wr || wr_en !== 16'hFFFF) begin
            errors++;
            $display("FAIL map2_write got bank=%h row=%h want bank=%h row=%h", wr_bank, wr_row, wb, wr);
        end
        for (int k = 0; k < LANES; k++) seen[wr_bank[k*4 +: 4]] = 1'b1;
        checks++;
        if (seen !== 16'hFFFF) begin
            errors++;
            $display("FAIL map2_distinct got bank set %h want ffff", seen);
        end
    endtask

    task automatic test_full_overflow();
        grp_t g [9];
        for (int i = 0; i < 9; i++) g[i] = rand_grp();
        for (int i = 0; i < 8; i++) cycle(1'b1, g[i], 1'b0, 1'b0);
        checks++;
        if (fifo_full !== 1'b1 || overflow !== 1'b0 || fifo_empty !== 1'b0) begin
            errors++;
            $display("FAIL full_after8 got full=%b ovf=%b empty=%b want 1 0 0", fifo_full, overflow, fifo_empty);
        end
        cycle(1'b1, g[8], 1'b0, 1'b0);
        checks++;
        if (overflow !== 1'b1 || fifo_full !== 1'b1) begin
            errors++;
            $display("FAIL overflow_9th got ovf=%b full=%b want 1 1", overflow, fifo_full);
        end
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            checks++;
            if (wr_en !== 16'hFFFF || wr_row !== row_of(g[i]) || wr_bank !== bank_of(g[i])) begin
                errors++;
                $display("FAIL order_pop%0d got row=%h bank=%h want row=%h bank=%h",
                         i, wr_row, wr_bank, row_of(g[i]), bank_of(g[i]));
            end
        end
        checks++;
        if (fifo_empty !== 1'b1 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL drained got %h want %h", dut_vec, exp_vec());
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (wr_en !== 16'h0000 || overflow !== 1'b1 || underflow !== 1'b1) begin
            errors++;
            $display("FAIL no_9th got en=%h ovf=%b udf=%b want 0000 1 1", wr_en, overflow, underflow);
        end
    endtask

    task automatic test_underflow();
        grp_t g = rand_grp();
        do_reset();
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (underflow !== 1'b1 || wr_en !== 16'h0000 || fifo_empty !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL underflow got udf=%b en=%h empty=%b ovf=%b want 1 0000 1 0",
                     underflow, wr_en, fifo_empty, overflow);
        end
        cycle(1'b1, g, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (wr_stage !== 2'd0 || wr_row !== row_of(g) || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL underflow_after got %h want %h", dut_vec, exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, rand_grp(), 1'b0, 1'b0);
        for (int i = 1; i <= 768; i++) begin
            logic [1:0] s = 2'((i - 1) / 256);
            cycle(1'b1, rand_grp(), 1'b1, 1'b0);
            checks++;
            if (wr_stage !== s || wb_done !== (i == 768)) begin
                errors++;
                $display("FAIL b2b_write%0d got stg=%0d done=%b want stg=%0d done=%b",
                         i, wr_stage, wb_done, s, i == 768);
            end
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL b2b_model%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (wr_stage !== 2'd0 || wb_done !== 1'b0 || wr_en !== 16'hFFFF) begin
            errors++;
            $display("FAIL b2b_wrap got stg=%0d done=%b en=%h want 0 0 ffff", wr_stage, wb_done, wr_en);
        end
    endtask

    // Leaves 5 groups held, overflow set and a write on the outputs.
    task automatic fill_five();
        for (int i = 0; i < 9; i++) cycle(1'b1, rand_grp(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle(1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        cycle(1'b0, '0, 1'b0, 1'b1);
        fill_five();
        checks++;
        if (wr_en !== 16'hFFFF || overflow !== 1'b1 || mq.size() != 5 || dut_vec !== exp_vec()) begin
            errors++;
            $display("FAIL arst_setup got %h want %h", dut_vec, exp_vec());
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (dut_vec !== VW'(4)) begin
            errors++;
            $display("FAIL arst_immediate got %h want %h", dut_vec, VW'(4));
        end
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_clear();
        grp_t g = rand_grp();
        cycle(1'b0, '0, 1'b1, 1'b0);
        fill_five();
        checks++;
        if (underflow !== 1'b1 || overflow !== 1'b1 || wr_en !== 16'hFFFF) begin
            errors++;
            $display("FAIL clear_setup got udf=%b ovf=%b en=%h want 1 1 ffff", underflow, overflow, wr_en);
        end
        cycle(1'b1, rand_grp(), 1'b1, 1'b1);
        checks++;
        if (dut_vec !== VW'(4)) begin
            errors++;
            $display("FAIL clear_state got %h want %h", dut_vec, VW'(4));
        end
        cycle(1'b1, g, 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        checks++;
        if (wr_row !== row_of(g) || wr_stage !== 2'd0 || fifo_empty !== 1'b1) begin
            errors++;
            $display("FAIL clear_after got row=%h stg=%0d empty=%b want row=%h 0 1",
                     wr_row, wr_stage, fifo_empty, row_of(g));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 600; i++) begin
            int pv = (i / 100) % 2 == 0 ? 75 : 40;
            logic v  = ($urandom % 100) < pv;
            logic rv = ($urandom % 100) < (100 - pv + 10);
            logic c  = ($urandom % 97) == 0;
            cycle(v, rand_grp(), rv, c);
            checks++;
            if (dut_vec !== exp_vec()) begin
                errors++;
                $display("FAIL random%0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_map_bank_k();
        test_map_shift();
        test_full_overflow();
        test_underflow();
        test_back_to_back();
        test_async_reset();
        test_clear();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
